// File: rtl/ni_pkt_inject.sv
// Source-side packetizer: turns a packet request plus a payload word stream into
// head/body/tail flits for a router local port, gated by per-VC credits.
module ni_pkt_inject #(
  parameter int DATAW    = 32,
  parameter int COORDW   = 4,
  parameter int NVC      = 2,
  parameter int VCW      = 1,
  parameter int BUFDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [COORDW-1:0] my_xpos,
  input  logic [COORDW-1:0] my_ypos,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [COORDW-1:0] req_dstx,
  input  logic [COORDW-1:0] req_dsty,
  input  logic [VCW-1:0]    req_vch,
  input  logic [7:0]        req_len,
  input  logic              dat_valid,
  output logic              dat_ready,
  input  logic [DATAW-1:0]  dat_in,
  output logic [DATAW+1:0]  flit_out,
  output logic              flit_valid,
  output logic [VCW-1:0]    flit_vch,
  input  logic [NVC-1:0]    credit_in,
  output logic              credit_err,
  output logic              busy
);

  localparam int CNTW = $clog2(BUFDEPTH + 1);

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  state_t                    state_reg, state_next;
  logic [COORDW-1:0]         dstx_reg, dsty_reg, srcx_reg, srcy_reg;
  logic [VCW-1:0]            vch_reg;
  logic [7:0]                len_reg, rem_reg;
  logic [NVC-1:0][CNTW-1:0]  credit_cnt_reg, credit_next;
  logic [NVC-1:0]            sent_v, overflow;
  logic                      credit_err_reg;
  logic [DATAW+1:0]          flit_out_reg;
  logic                      flit_valid_reg;
  logic [VCW-1:0]            flit_vch_reg;

  logic                      req_accept, head_send, body_send, send_any, has_credit;
  logic [7:0]                len_fix;
  logic [DATAW-1:0]          head_payload;

  assign len_fix    = (req_len == 8'd0) ? 8'd1 : req_len;
  assign has_credit = (credit_cnt_reg[vch_reg] != '0);
  assign send_any   = head_send | body_send;

  // Per-VC credit bookkeeping: a return at full depth without a send is an overflow.
  generate
    for (genvar gi = 0; gi < NVC; gi++) begin : g_credit
      assign sent_v[gi]      = send_any && (vch_reg == VCW'(gi));
      assign overflow[gi]    = credit_in[gi] && !sent_v[gi] &&
                               (credit_cnt_reg[gi] == CNTW'(BUFDEPTH));
      assign credit_next[gi] = overflow[gi] ? credit_cnt_reg[gi] :
                               credit_cnt_reg[gi] - {{(CNTW-1){1'b0}}, sent_v[gi]}
                                                  + {{(CNTW-1){1'b0}}, credit_in[gi]};
    end
  endgenerate

  always_comb begin
    head_payload = '0;
    head_payload[0  +: COORDW] = dstx_reg;
    head_payload[4  +: COORDW] = dsty_reg;
    head_payload[8  +: COORDW] = srcx_reg;
    head_payload[12 +: COORDW] = srcy_reg;
    head_payload[16 +: 8]      = len_reg;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    dat_ready  = 1'b0;
    req_accept = 1'b0;
    head_send  = 1'b0;
    body_send  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready  = 1'b1;
        req_accept = req_valid;
        if (req_valid) state_next = HEAD;
      end
      HEAD: begin
        head_send = has_credit;
        if (has_credit) state_next = BODY;
      end
      BODY: begin
        dat_ready = has_credit;
        body_send = dat_valid && has_credit;
        if (body_send && rem_reg == 8'd1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state_reg      <= IDLE;
      dstx_reg       <= '0;
      dsty_reg       <= '0;
      srcx_reg       <= '0;
      srcy_reg       <= '0;
      vch_reg        <= '0;
      len_reg        <= '0;
      rem_reg        <= '0;
      credit_cnt_reg <= {NVC{CNTW'(BUFDEPTH)}};
      credit_err_reg <= 1'b0;
      flit_out_reg   <= '0;
      flit_valid_reg <= 1'b0;
      flit_vch_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      credit_cnt_reg <= credit_next;
      credit_err_reg <= credit_err_reg | (|overflow);
      flit_valid_reg <= send_any;
      if (req_accept) begin
        dstx_reg <= req_dstx;
        dsty_reg <= req_dsty;
        srcx_reg <= my_xpos;
        srcy_reg <= my_ypos;
        vch_reg  <= req_vch;
        len_reg  <= len_fix;
        rem_reg  <= len_fix;
      end
      if (head_send) begin
        flit_out_reg <= {2'b01, head_payload};
        flit_vch_reg <= vch_reg;
      end else if (body_send) begin
        flit_out_reg <= {(rem_reg == 8'd1) ? 2'b11 : 2'b10, dat_in};
        flit_vch_reg <= vch_reg;
        rem_reg      <= rem_reg - 8'd1;
      end
    end
  end

  assign flit_out   = flit_out_reg;
  assign flit_valid = flit_valid_reg;
  assign flit_vch   = flit_vch_reg;
  assign credit_err = credit_err_reg;
  assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_ni_pkt_inject.sv
// Scoreboard bench for ni_pkt_inject: expected flits are queued as requests and
// payload words are driven, then popped and compared as flits leave the DUT.
module tb_ni_pkt_inject;

  localparam int DATAW    = 32;
  localparam int COORDW   = 4;
  localparam int NVC      = 2;
  localparam int VCW      = 1;
  localparam int BUFDEPTH = 4;

  logic              clk;
  logic              rst_;
  logic [COORDW-1:0] my_xpos, my_ypos;
  logic              req_valid, req_ready;
  logic [COORDW-1:0] req_dstx, req_dsty;
  logic [VCW-1:0]    req_vch;
  logic [7:0]        req_len;
  logic              dat_valid, dat_ready;
  logic [DATAW-1:0]  dat_in;
  logic [DATAW+1:0]  flit_out;
  logic              flit_valid;
  logic [VCW-1:0]    flit_vch;
  logic [NVC-1:0]    credit_in;
  logic              credit_err;
  logic              busy;

  ni_pkt_inject #(
    .DATAW(DATAW), .COORDW(COORDW), .NVC(NVC), .VCW(VCW), .BUFDEPTH(BUFDEPTH)
  ) dut (
    .clk(clk), .rst_(rst_), .my_xpos(my_xpos), .my_ypos(my_ypos),
    .req_valid(req_valid), .req_ready(req_ready), .req_dstx(req_dstx),
    .req_dsty(req_dsty), .req_vch(req_vch), .req_len(req_len),
    .dat_valid(dat_valid), .dat_ready(dat_ready), .dat_in(dat_in),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_vch(flit_vch),
    .credit_in(credit_in), .credit_err(credit_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  logic [63:0] exp_q[$];
  int          obs_cyc[$];
  logic        cur_vc;
  int          cur_len, cur_idx;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] head_exp(input logic [3:0] dx, input logic [3:0] dy,
                                           input logic [3:0] sx, input logic [3:0] sy,
                                           input logic vc, input logic [7:0] len);
    logic [31:0] p;
    p = 32'd0;
    p[3:0]   = dx;
    p[7:4]   = dy;
    p[11:8]  = sx;
    p[15:12] = sy;
    p[23:16] = (len == 8'd0) ? 8'd1 : len;
    return {29'd0, vc, 2'b01, p};
  endfunction

  always @(negedge clk) begin
    if (flit_valid) begin
      $display("flit cyc=%0d vch=%0d type=%0d data=%h", cyc, flit_vch, flit_out[33:32], flit_out[31:0]);
      if (exp_q.size() == 0) begin
        chk("flit_expected", 64'(exp_q.size() > 0), 64'd1);
      end else begin
        chk("flit", {29'd0, flit_vch, flit_out}, exp_q.pop_front());
        obs_cyc.push_back(cyc);
      end
    end
  end

  // Called at a falling edge; returns the cycle count seen just before the accept edge.
  task automatic do_req(input logic [3:0] dx, input logic [3:0] dy, input logic vc,
                        input logic [7:0] len, output int k);
    int t;
    req_valid = 1'b1; req_dstx = dx; req_dsty = dy; req_vch = vc; req_len = len;
    t = 0;
    while (!req_ready && t < 50) begin @(negedge clk); t++; end
    chk("req_accept", 64'(req_ready), 64'd1);
    k = cyc;
    exp_q.push_back(head_exp(dx, dy, my_xpos, my_ypos, vc, len));
    cur_vc = vc; cur_len = (len == 8'd0) ? 1 : int'(len); cur_idx = 0;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w);
    int t;
    dat_valid = 1'b1; dat_in = w;
    t = 0;
    while (!dat_ready && t < 50) begin @(negedge clk); t++; end
    chk("dat_accept", 64'(dat_ready), 64'd1);
    if (dat_ready) begin
      exp_q.push_back({29'd0, cur_vc, (cur_idx == cur_len - 1) ? 2'b11 : 2'b10, w});
      cur_idx++;
      @(negedge clk);
    end
    dat_valid = 1'b0;
  endtask

  task automatic pulse(input logic [NVC-1:0] m);
    credit_in = m;
    @(negedge clk);
    credit_in = '0;
  endtask

  task automatic restore(input logic [NVC-1:0] m, input int n);
    repeat (n) pulse(m);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_flit_valid"}, 64'(flit_valid), 64'd0);
    chk({tag, "_busy"},       64'(busy), 64'd0);
    chk({tag, "_req_ready"},  64'(req_ready), 64'd1);
    chk({tag, "_dat_ready"},  64'(dat_ready), 64'd0);
    chk({tag, "_credit_err"}, 64'(credit_err), 64'd0);
    chk({tag, "_cnt0"},       64'(dut.credit_cnt_reg[0]), 64'(BUFDEPTH));
    chk({tag, "_cnt1"},       64'(dut.credit_cnt_reg[1]), 64'(BUFDEPTH));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_ = 1'b1; my_xpos = 4'd1; my_ypos = 4'd1;
    req_valid = 1'b0; req_dstx = '0; req_dsty = '0; req_vch = '0; req_len = '0;
    dat_valid = 1'b0; dat_in = '0; credit_in = '0;
    repeat (2) @(negedge clk);
    check_idle_reset("rst0");
    chk("rst0_flit_out", 64'(flit_out), 64'd0);
    rst_ = 1'b0;
    @(negedge clk);

    // Minimal packet, minimum latency
    obs_cyc.delete();
    do_req(4'd3, 4'd1, 1'b0, 8'd2, k);
    push_word(32'hA);
    push_word(32'hB);
    chk("t2_req_ready_after_tail", 64'(req_ready), 64'd1);
    drain();
    chk("t2_nflits", 64'(obs_cyc.size()), 64'd3);
    if (obs_cyc.size() == 3) begin
      chk("t2_head_cyc", 64'(obs_cyc[0] - k), 64'd2);
      chk("t2_body_cyc", 64'(obs_cyc[1] - k), 64'd3);
      chk("t2_tail_cyc", 64'(obs_cyc[2] - k), 64'd4);
    end
    restore(2'b01, 3);
    chk("t2_cnt0", 64'(dut.credit_cnt_reg[0]), 64'(BUFDEPTH));

    // Credit exhaustion on VC1
    do_req(4'd2, 4'd0, 1'b1, 8'd5, k);
    for (int i = 0; i < 3; i++) push_word(32'h100 + i);
    dat_valid = 1'b1; dat_in = 32'h103;
    repeat (3) begin @(negedge clk); chk("t3_stall1", 64'(dat_ready), 64'd0); end
    pulse(2'b10);
    push_word(32'h103);
    dat_valid = 1'b1; dat_in = 32'h104;
    repeat (3) begin @(negedge clk); chk("t3_stall2", 64'(dat_ready), 64'd0); end
    chk("t3_one_more_only", 64'(exp_q.size()), 64'd0);
    pulse(2'b10);
    push_word(32'h104);
    drain();
    chk("t3_idle", 64'(busy), 64'd0);
    restore(2'b10, 4);

    // Send and return on the same VC in the same cycle
    do_req(4'd0, 4'd2, 1'b0, 8'd5, k);
    push_word(32'h200);
    push_word(32'h201);
    chk("t4_cnt_before", 64'(dut.credit_cnt_reg[0]), 64'd1);
    dat_valid = 1'b1; dat_in = 32'h202; credit_in = 2'b01;
    chk("t4_ready", 64'(dat_ready), 64'd1);
    exp_q.push_back({29'd0, 1'b0, 2'b10, 32'h202});
    cur_idx++;
    @(negedge clk);
    credit_in = '0;
    chk("t4_cnt_same", 64'(dut.credit_cnt_reg[0]), 64'd1);
    chk("t4_not_blocked", 64'(dat_ready), 64'd1);
    push_word(32'h203);
    dat_valid = 1'b1; dat_in = 32'h204;
    @(negedge clk);
    chk("t4_stall", 64'(dat_ready), 64'd0);
    pulse(2'b01);
    push_word(32'h204);
    drain();
    restore(2'b01, 4);
    chk("t4_cnt0", 64'(dut.credit_cnt_reg[0]), 64'(BUFDEPTH));

    // Overflow return while idle at full depth
    chk("t5_err_before", 64'(credit_err), 64'd0);
    pulse(2'b01);
    chk("t5_err_set", 64'(credit_err), 64'd1);
    chk("t5_cnt_hold", 64'(dut.credit_cnt_reg[0]), 64'(BUFDEPTH));
    do_req(4'd5, 4'd6, 1'b1, 8'd1, k);
    push_word(32'h300);
    drain();
    restore(2'b10, 2);
    chk("t5_err_sticky", 64'(credit_err), 64'd1);
    chk("t5_cnt1", 64'(dut.credit_cnt_reg[1]), 64'(BUFDEPTH));

    // Zero-length request becomes a single tail
    obs_cyc.delete();
    do_req(4'd7, 4'd7, 1'b0, 8'd0, k);
    push_word(32'h400);
    drain();
    chk("t6_len0_nflits", 64'(obs_cyc.size()), 64'd2);
    restore(2'b01, 2);

    // Reset in the middle of a packet
    do_req(4'd1, 4'd2, 1'b1, 8'd3, k);
    push_word(32'h500);
    dat_valid = 1'b1; dat_in = 32'h501;
    #2 rst_ = 1'b1;
    #1 check_idle_reset("rst_mid");
    @(negedge clk);
    rst_ = 1'b0;
    dat_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_mid_no_flits", 64'(exp_q.size()), 64'd0);
    do_req(4'd4, 4'd3, 1'b0, 8'd2, k);
    push_word(32'h600);
    push_word(32'h601);
    drain();
    chk("post_rst_idle", 64'(req_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ni_pkt_inject.md
Name: ni_pkt_inject

Overview:
Source-side network-interface packetizer that feeds a router local input port, which is the producer of the header flits that router route computation consumes. It accepts a packet request (destination X/Y, VC, payload length) and a payload word stream. It emits a head flit carrying destination and source coordinates, then body flits and a final tail flit. Injection is gated by per-VC credit-based flow control against the downstream input buffer.

Parameters:
DATAW, 32, flit payload width (type field excluded)
COORDW, 4, X/Y coordinate width
NVC, 2, number of virtual channels
VCW, 1, VC index width (clog2 NVC)
BUFDEPTH, 4, downstream buffer depth per VC; credit counter reset value and maximum

Ports:
clk  in  1  clock, all state updates on rising edge
rst_  in  1  asynchronous, active-high reset (asserted = 1)
my_xpos  in  COORDW  local node X, sampled at request accept
my_ypos  in  COORDW  local node Y, sampled at request accept
req_valid  in  1  packet request valid
req_ready  out  1  request accepted when both valid and ready are high
req_dstx  in  COORDW  destination X
req_dsty  in  COORDW  destination Y
req_vch  in  VCW  VC for the whole packet
req_len  in  8  payload flit count; 0 is treated as 1
dat_valid  in  1  payload word valid
dat_ready  out  1  payload word consumed when both valid and ready are high
dat_in  in  DATAW  payload word
flit_out  out  DATAW+2  {type[1:0], payload}; type 01 head, 10 body, 11 tail, 00 idle
flit_valid  out  1  one-cycle qualifier per flit
flit_vch  out  VCW  VC of the current flit
credit_in  in  NVC  per-VC credit-return pulse, one bit per VC
credit_err  out  1  sticky credit-overflow flag
busy  out  1  high when not in IDLE

Behaviour:
- Reset (asynchronous, immediate):
  - state IDLE; flit_out 0; flit_valid 0; flit_vch 0; credit_err 0.
  - All credit counters set to BUFDEPTH.
  - req_ready is 1 after reset; dat_ready 0; busy 0.
  - A packet in flight when reset asserts is abandoned; no tail is emitted.
- FSM states: IDLE, HEAD, BODY.
- IDLE:
  - req_ready = 1.
  - On accept, register dstx, dsty, vch, my_xpos, my_ypos, and len (len 0 becomes 1) into the remaining counter `rem`; go to HEAD.
- HEAD:
  - On an edge where credit[vch] > 0, register the head flit, pulse flit_valid for the next cycle, and go to BODY.
  - Otherwise stall in HEAD with flit_valid 0.
- Head payload layout:
  - [3:0] dstx, [7:4] dsty, [11:8] srcx, [15:12] srcy, [23:16] len (after the 0-to-1 fix), upper bits 0.
- BODY:
  - dat_ready = credit[vch] > 0, evaluated combinationally from the current count.
  - On a dat_valid/dat_ready edge: flit_out = {type, dat_in}, flit_valid = 1 next cycle, `rem` decrements.
  - Type is tail when `rem` == 1, else body.
  - After the tail edge, go to IDLE; req_ready is high in the following cycle.
- flit_valid is 0 in every cycle not preceded by a send edge. flit_out holds its last value while flit_valid is 0.
- Minimum timing:
  - Accept edge E0, head sent at E1, first payload at E2.
  - Back-to-back body flits, one per cycle, when data and credit are available.
- Credit counters, per VC, 0..BUFDEPTH:
  - Next value = count − sent + credit_in[v].
  - A send and a return on the same VC in the same cycle leave the count unchanged.
  - A return when count = BUFDEPTH with no send that cycle holds at BUFDEPTH and sets credit_err (sticky until reset).
  - A send never occurs at count 0.
- Request inputs are ignored outside IDLE. dat_in is ignored outside BODY.

Test Plan:
1. Assert rst_ mid-run -> flit_valid=0, busy=0, req_ready=1, dat_ready=0, credit_err=0 immediately, before the next clock edge; both VC counters read 4.
2. Node (1,1), request dst (3,1), vch 0, len 2, dat 0xA then 0xB with credit available -> head {01,32'h00021113} one cycle after the accept edge, then {10,0xA}, then {11,0xB} on consecutive cycles; req_ready high the cycle after the tail.
3. Request vch 1, len 5, no credit returns -> head plus 3 body flits sent, then dat_ready=0 and the stall holds; one credit_in[1] pulse -> exactly one more body flit; a second pulse -> tail.
4. With vch 0 credit at 1, send a body flit while pulsing credit_in[0] in the same cycle -> count stays 1, next flit is not blocked.
5. Pulse credit_in[0] while idle at count 4 -> credit_err=1 and stays 1 through later packets until reset; count remains 4.
6. Request len 0 -> head carries len field 1 and exactly one tail flit follows; assert rst_ in the middle of a len-3 packet -> no further flits, and a new request is accepted normally.
